// File: rtl/mult_seq_if.sv
// Request/result bundle between the execute stage and the sequential multiplier.
// A start is taken on an enabled edge when start_mult, module_en and ready are all 1; otherwise it is dropped.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             clk_en;
    logic             module_en;
    logic             start_mult;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       fsm_state;

    modport master (
        output clk_en, module_en, start_mult, is_signed, op_a, op_b,
        input  ready, done, hi, lo, fsm_state
    );

    modport slave (
        input  clk_en, module_en, start_mult, is_signed, op_a, op_b,
        output ready, done, hi, lo, fsm_state
    );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier for MULT/MULTU: one product bit per enabled clock,
// full 2*WIDTH-bit result presented on hi/lo with a done pulse.
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH:0]     acc_step;
    logic [2*WIDTH:0]     acc_nx;
    logic [WIDTH:0]       upper_sum;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   result;
    logic                 accept;
    logic                 last_iter;

    assign accept    = (state == IDLE) && bus.module_en && bus.start_mult;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Negating the most negative value wraps back onto itself, which is exactly
    // its unsigned magnitude, so no extra bit is needed.
    assign mag_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign mag_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

    assign upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    assign acc_step  = mplier[0] ? {upper_sum, acc[WIDTH-1:0]} : acc;
    assign acc_nx    = {1'b0, acc_step[2*WIDTH:1]};
    assign product   = acc[2*WIDTH-1:0];
    assign result    = neg ? -product : product;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.module_en && bus.start_mult) state_nx = RUN;
            RUN: begin
                if (!bus.module_en)  state_nx = IDLE;
                else if (last_iter)  state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          state <= IDLE;
        else if (bus.clk_en) state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (bus.clk_en) begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (!bus.module_en) begin
                        done_q <= 1'b0;
                    end else begin
                        acc    <= acc_nx;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    // An abort in the final cycle leaves the previous result visible.
                    if (!bus.module_en) begin
                        done_q <= 1'b0;
                    end else begin
                        {hi_q, lo_q} <= result;
                        done_q       <= 1'b1;
                    end
                end
                default: done_q <= 1'b0;
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomized checks of mult_seq against a 64-bit arithmetic model.
module tb_mult_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult_seq_if #(.WIDTH(32)) bus ();

    mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s);
        bus.clk_en     = 1'b1;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.is_signed  = s;
        bus.start_mult = 1'b1;
        step();
        bus.start_mult = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
        bus.is_signed  = 1'($urandom_range(0, 1));
    endtask

    // mode 0: clk_en always 1, mode 1: toggle every cycle, mode 2: random stalls
    task automatic wait_done(input int mode, output int en_edges, output int ready_hi);
        en_edges = 0;
        ready_hi = 0;
        for (int i = 0; i < 400; i++) begin
            if (mode == 1)      bus.clk_en = ~bus.clk_en;
            else if (mode == 2) bus.clk_en = ($urandom_range(0, 3) != 0);
            else                bus.clk_en = 1'b1;
            step();
            if (bus.clk_en) en_edges++;
            if (bus.done) return;
            if (bus.ready) ready_hi++;
        end
        chk("done_timeout", 64'(bus.done), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input int mode, output logic [63:0] res);
        int en_edges;
        int ready_hi;
        start_op(a, b, s);
        wait_done(mode, en_edges, ready_hi);
        chk({tag, "_latency"}, 64'(en_edges), 64'd33);
        chk({tag, "_ready_busy"}, 64'(ready_hi), 64'd0);
        chk({tag, "_ready_end"}, 64'(bus.ready), 64'd1);
        res = {bus.hi, bus.lo};
    endtask

    initial begin
        logic [63:0] res;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.clk_en     = 1'b1;
        bus.module_en  = 1'b1;
        bus.start_mult = 1'b0;
        bus.is_signed  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        #12;
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        step();

        run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, res);
        chk("umax_prod", res, 64'hFFFF_FFFE_0000_0001);
        chk("umax_done", 64'(bus.done), 64'd1);

        run_op("s_m1x5", 32'hFFFF_FFFF, 32'd5, 1'b1, 0, res);
        chk("s_m1x5_prod", res, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op("u_m1x5", 32'hFFFF_FFFF, 32'd5, 1'b0, 0, res);
        chk("u_m1x5_prod", res, 64'h0000_0004_FFFF_FFFB);
        run_op("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, res);
        chk("s_min2_prod", res, 64'h4000_0000_0000_0000);
        run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 0, res);
        chk("s_minx1_prod", res, 64'hFFFF_FFFF_8000_0000);

        run_op("stall", 32'd7, 32'd6, 1'b0, 1, res);
        chk("stall_prod", res, 64'd42);
        bus.clk_en = 1'b0;
        step();
        chk("stall_hold1", 64'(bus.done), 64'd1);
        step();
        chk("stall_hold2", 64'(bus.done), 64'd1);
        bus.clk_en = 1'b1;
        step();
        chk("stall_clear", 64'(bus.done), 64'd0);

        start_op(32'd3, 32'd3, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            if (e == 5) begin
                bus.start_mult = 1'b1;
                bus.op_a       = 32'd100;
            end
            if (e == 10) bus.module_en = 1'b0;
            step();
            bus.start_mult = 1'b0;
            if (e == 5) chk("busy_ignored", 64'(bus.ready), 64'd0);
        end
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd42);
        step();
        chk("abort_done2", 64'(bus.done), 64'd0);
        bus.module_en = 1'b1;
        run_op("restart", 32'd3, 32'd3, 1'b0, 0, res);
        chk("restart_prod", res, 64'd9);

        start_op($urandom, $urandom, 1'b0);
        for (int e = 1; e <= 15; e++) step();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.ready), 64'd1);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        #3 rst_n = 1'b1;
        step();
        run_op("post_rst", 32'd2, 32'd2, 1'b0, 0, res);
        chk("post_rst_prod", res, 64'd4);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       begin ra = 32'h8000_0000; rb = $urandom; end
                1:       begin ra = $urandom_range(0, 255); rb = 32'hFFFF_FFFF - $urandom_range(0, 3); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rs, ($urandom_range(0, 1) == 1) ? 2 : 0, res);
            chk("rand_prod", res, ref_prod(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Iterative shift-add multiplier for the MIPS MULT/MULTU instructions. Companion to the core's sequential divider.
- Takes two WIDTH-bit operands and produces the full 2*WIDTH-bit product on the hi/lo outputs, one bit per enabled clock.
- Sits beside the divider in the execute stage and uses the same control style: clk_en, module_en, start pulse, ready flag.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- clk_en  in  1  clock enable; when 0 every register holds.
- module_en  in  1  block enable; when 0, start_mult is ignored and any running operation aborts.
- start_mult  in  1  start request; sampled only when ready=1.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start_mult.
- op_a  in  WIDTH  multiplicand; sampled with start_mult.
- op_b  in  WIDTH  multiplier; sampled with start_mult.
- ready  out  1  1 = idle and able to accept a start.
- done  out  1  one-enabled-cycle pulse when hi/lo update.
- hi  out  WIDTH  upper half of the product.
- lo  out  WIDTH  lower half of the product.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, hi=0, lo=0; internal accumulator, counter and sign flag cleared. Reset mid-operation discards the operation; no done pulse.
- Enabled edge: a rising clk with clk_en=1. With clk_en=0 all state, including done, holds. A done pulse therefore stretches until the next enabled edge.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On an enabled edge with module_en=1 and start_mult=1: latch operand magnitudes (|op| when is_signed=1, raw operands otherwise).
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Clear accumulator, counter=0, go to RUN, ready=0.
  - done clears on any enabled edge in IDLE without a new completion.
- Magnitude of the most negative value (0x80000000) is treated as the unsigned value 0x80000000; no overflow.
- RUN, per enabled edge: if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH+1-bit accumulator. Then shift accumulator and multiplier right 1 and increment counter. After WIDTH iterations go to FIN.
- FIN, one enabled edge:
  - hi:lo <= neg ? two's-complement negation of the product : product.
  - done=1, ready=1, state=IDLE.
- Latency: start accepted at enabled edge E0; result and done visible after edge E(WIDTH+1), i.e. 33 enabled edges for WIDTH=32. Earliest back-to-back start is accepted at E(WIDTH+2).
- start_mult while ready=0: ignored; no queueing.
- module_en=0 on an enabled edge in RUN or FIN: abort to IDLE, ready=1, done=0, hi/lo keep previous values.
- hi/lo change only in FIN or on reset; they hold the last result indefinitely.
- Operand inputs are don't-care after the accept edge.

Test Plan:
- Unsigned max: reset, start is_signed=0, op_a=op_b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001, done=1 exactly after the 33rd enabled edge following start, ready low for edges 1..32.
- Signed vs unsigned: op_a=0xFFFFFFFF, op_b=5.
  - is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
  - is_signed=0 -> hi=0x00000004, lo=0xFFFFFFFB.
- Signed corner: op_a=op_b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000. Also 0x80000000 * 1 signed -> hi=0xFFFFFFFF, lo=0x80000000.
- clk_en stall: 7*6 unsigned with clk_en toggling 1/0 each cycle -> hi=0, lo=42, done after 33 enabled (≈66 total) edges; done held high while clk_en=0.
- Abort and busy: previous result hi=0, lo=42.
  - Start 3*3, pulse start_mult again at edge 5 -> ignored.
  - Drop module_en at edge 10 -> ready=1 next edge, no done, hi/lo stay 0/42.
  - Restart 3*3 -> lo=9.
- Reset mid-run: assert rst_n=0 asynchronously at edge 15 of a run -> ready=1, done=0, hi=lo=0 immediately without waiting for a clock edge. After release, a new start of 2*2 completes normally with lo=4.
